// File: rtl/acorn_pkg.sv
// Shared ACORN-128 constants, finalization FSM encoding and the boolean helpers
// used by the keystream and feedback functions.
package acorn_pkg;

   localparam int STATE_W   = 293;
   localparam int TAG_W     = 128;
   localparam int N_STEPS   = 768;
   localparam int TAG_START = N_STEPS - TAG_W;
   localparam int CNT_W     = 10;

   localparam logic [CNT_W-1:0] CNT_TAG_START = CNT_W'(TAG_START);
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(N_STEPS - 1);

   localparam logic [1:0] FSM_IDLE = 2'd0;
   localparam logic [1:0] FSM_RUN  = 2'd1;
   localparam logic [1:0] FSM_DONE = 2'd2;

   typedef logic [STATE_W-1:0] acorn_state_t;
   typedef logic [TAG_W-1:0]   acorn_tag_t;

   function automatic logic maj3(input logic x, input logic y, input logic z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

   function automatic logic ch3(input logic x, input logic y, input logic z);
      return (x & y) ^ (~x & z);
   endfunction

endpackage

// File: rtl/finalization_tag_steps.sv
// ACORN-128 step primitives: keystream bit generation and the one-step state
// update (LFSR mixing, nonlinear feedback, shift).
module ksg128
   import acorn_pkg::*;
(
   input  logic [STATE_W-1:0] state_in,
   output logic               ks_out
);

   logic mix61;
   logic mix154;
   logic mix193;
   logic mix230;
   logic unusedState;

   // The keystream sees the state after this step's LFSR mixing, so the four
   // mixed taps it needs are rebuilt here from the raw register.
   assign mix61  = state_in[61]  ^ state_in[23]  ^ state_in[0];
   assign mix154 = state_in[154] ^ state_in[111] ^ state_in[107];
   assign mix193 = state_in[193] ^ state_in[160] ^ state_in[154];
   assign mix230 = state_in[230] ^ state_in[196] ^ state_in[193];

   assign ks_out = state_in[12] ^ mix154
                 ^ maj3(state_in[235], mix61, mix193)
                 ^ ch3(mix230, state_in[111], state_in[66]);

   assign unusedState = ^state_in;

endmodule

module state_update128
   import acorn_pkg::*;
(
   input  logic [STATE_W-1:0] state_in,
   input  logic               ks_in,
   input  logic               ca_in,
   input  logic               cb_in,
   input  logic               mbit_in,
   output logic [STATE_W-1:0] state_out
);

   logic [STATE_W-1:0] mixed;
   logic               fbk;

   // Every mixing source is read before it is itself rewritten, so all terms
   // can be taken from the unmodified input.
   always_comb begin
      mixed      = state_in;
      mixed[289] = state_in[289] ^ state_in[235] ^ state_in[230];
      mixed[230] = state_in[230] ^ state_in[196] ^ state_in[193];
      mixed[193] = state_in[193] ^ state_in[160] ^ state_in[154];
      mixed[154] = state_in[154] ^ state_in[111] ^ state_in[107];
      mixed[107] = state_in[107] ^ state_in[66]  ^ state_in[61];
      mixed[61]  = state_in[61]  ^ state_in[23]  ^ state_in[0];
   end

   assign fbk = mixed[0] ^ ~mixed[107]
              ^ maj3(mixed[244], mixed[23], mixed[160])
              ^ (ca_in & mixed[196])
              ^ (cb_in & ks_in);

   assign state_out = {fbk ^ mbit_in, mixed[STATE_W-1:1]};

endmodule

// File: rtl/finalization_tag.sv
// ACORN-128 finalization: 768 update steps with m=0, ca=cb=1, collecting the
// keystream of the last 128 steps as the authentication tag.
module finalization_tag
   import acorn_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] state_in,
   output logic               busy,
   output logic               done,
   output logic [TAG_W-1:0]   tag_out,
   output logic [STATE_W-1:0] state_out
);

   logic [1:0]       fsm_q,      fsm_d;
   logic [CNT_W-1:0] count_q,    count_d;
   acorn_state_t     stateReg_q, stateReg_d;
   acorn_tag_t       tag_q,      tag_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;
   acorn_tag_t       tagOut_q,   tagOut_d;
   acorn_state_t     stateOut_q, stateOut_d;

   acorn_state_t     stateNext;
   logic             ksBit;

   ksg128 uKsg (
      .state_in (stateReg_q),
      .ks_out   (ksBit)
   );

   state_update128 uUpdate (
      .state_in  (stateReg_q),
      .ks_in     (ksBit),
      .ca_in     (1'b1),
      .cb_in     (1'b1),
      .mbit_in   (1'b0),
      .state_out (stateNext)
   );

   // The tag shifts in from the top, so after 128 insertions the first
   // collected keystream bit has arrived at bit 0.
   always_comb begin
      fsm_d      = fsm_q;
      count_d    = count_q;
      stateReg_d = stateReg_q;
      tag_d      = tag_q;
      busy_d     = busy_q;
      done_d     = done_q;
      tagOut_d   = tagOut_q;
      stateOut_d = stateOut_q;

      case (fsm_q)
         FSM_RUN: begin
            stateReg_d = stateNext;
            if (count_q >= CNT_TAG_START) begin
               tag_d = {ksBit, tag_q[TAG_W-1:1]};
            end
            if (count_q == CNT_LAST) begin
               fsm_d      = FSM_DONE;
               count_d    = '0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               tagOut_d   = tag_d;
               stateOut_d = stateNext;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: begin
            if (start) begin
               fsm_d      = FSM_RUN;
               count_d    = '0;
               stateReg_d = state_in;
               tag_d      = '0;
               busy_d     = 1'b1;
               done_d     = 1'b0;
               tagOut_d   = '0;
               stateOut_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q      <= FSM_IDLE;
         count_q    <= '0;
         stateReg_q <= '0;
         tag_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tagOut_q   <= '0;
         stateOut_q <= '0;
      end else begin
         fsm_q      <= fsm_d;
         count_q    <= count_d;
         stateReg_q <= stateReg_d;
         tag_q      <= tag_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tagOut_q   <= tagOut_d;
         stateOut_q <= stateOut_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign tag_out   = tagOut_q;
   assign state_out = stateOut_q;

endmodule

// File: tb/tb_finalization_tag.sv
// Bench for finalization_tag: a whole-run behavioural ACORN model predicts the
// outputs each cycle; directed scenarios check latency, restart and reset.
module tb_finalization_tag;

   logic         clk;
   logic         rst;
   logic         start;
   logic [292:0] stateIn;
   logic         busy;
   logic         done;
   logic [127:0] tagOut;
   logic [292:0] stateOut;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit checkEn = 0;

   logic         mRun;
   int           mLeft;
   logic         mBusy;
   logic         mDone;
   logic [127:0] mTag;
   logic [292:0] mState;
   logic [127:0] pendTag;
   logic [292:0] pendState;
   logic [767:0] pendKs;

   finalization_tag dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .state_in  (stateIn),
      .busy      (busy),
      .done      (done),
      .tag_out   (tagOut),
      .state_out (stateOut)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One ACORN step written straight from the reference C code on a bit array.
   function automatic logic [292:0] modelStep(input logic [292:0] s, output logic ks);
      bit b[293];
      bit f;
      bit mj;
      for (int j = 0; j < 293; j++) b[j] = s[j];
      b[289] ^= b[235] ^ b[230];
      b[230] ^= b[196] ^ b[193];
      b[193] ^= b[160] ^ b[154];
      b[154] ^= b[111] ^ b[107];
      b[107] ^= b[66] ^ b[61];
      b[61]  ^= b[23] ^ b[0];
      mj = (b[235] & b[61]) | (b[235] & b[193]) | (b[61] & b[193]);
      ks = b[12] ^ b[154] ^ mj ^ (b[230] ? b[111] : b[66]);
      mj = (b[244] & b[23]) | (b[244] & b[160]) | (b[23] & b[160]);
      f  = b[0] ^ !b[107] ^ mj ^ b[196] ^ ks;
      for (int j = 0; j < 292; j++) b[j] = b[j+1];
      b[292] = f;
      for (int j = 0; j < 293; j++) modelStep[j] = b[j];
   endfunction

   task automatic computeFinal(input logic [292:0] s0, output logic [127:0] tag,
                               output logic [292:0] fin, output logic [767:0] ksAll);
      logic [292:0] s;
      logic         k;
      s     = s0;
      tag   = '0;
      ksAll = '0;
      for (int i = 0; i < 768; i++) begin
         s = modelStep(s, k);
         ksAll[i] = k;
         if (i >= 640) tag[i-640] = k;
      end
      fin = s;
   endtask

   function automatic logic [292:0] randState();
      logic [319:0] w;
      for (int i = 0; i < 10; i++) w[i*32 +: 32] = $urandom;
      return w[292:0];
   endfunction

   task automatic checkOutput(input string name, input logic [292:0] act, input logic [292:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transaction-level model: an accepted start yields the full result after 768 edges.
   initial begin
      mRun = 0; mLeft = 0; mBusy = 0; mDone = 0; mTag = '0; mState = '0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mRun = 0; mLeft = 0; mBusy = 0; mDone = 0; mTag = '0; mState = '0;
         end else begin
            cyc++;
            if (mRun) begin
               mLeft--;
               if (mLeft == 0) begin
                  mRun = 0; mBusy = 0; mDone = 1; mTag = pendTag; mState = pendState;
               end
            end else if (start) begin
               computeFinal(stateIn, pendTag, pendState, pendKs);
               mRun = 1; mLeft = 768; mBusy = 1; mDone = 0; mTag = '0; mState = '0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (checkEn) begin
            checkOutput("cycBusy",  293'(busy),   293'(mBusy));
            checkOutput("cycDone",  293'(done),   293'(mDone));
            checkOutput("cycTag",   293'(tagOut), 293'(mTag));
            checkOutput("cycState", stateOut,     mState);
         end
      end
   end

   task automatic applyStimulus(input logic [292:0] v);
      start   = 1'b1;
      stateIn = v;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Called at #1 after the accepting edge; returns the edge offset where done rose.
   task automatic runAndMeasure(input int injectAt, input logic [292:0] injectVal,
                                output int lat, output int busyCnt, output int riseCyc);
      lat = 0;
      busyCnt = 0;
      riseCyc = 0;
      if (busy) busyCnt++;
      for (int n = 1; n <= 2000; n++) begin
         if (injectAt > 0 && n == injectAt) begin
            start   = 1'b1;
            stateIn = injectVal;
         end
         if (injectAt > 0 && n == injectAt + 1) start = 1'b0;
         @(posedge clk);
         #1;
         if (done) begin
            lat = n;
            riseCyc = cyc;
            break;
         end
         if (busy) busyCnt++;
      end
   endtask

   logic [292:0] pinS;
   logic         pinKs;
   logic [127:0] eTag;
   logic [292:0] eFin;
   logic [767:0] eKs;
   logic [292:0] vA;
   logic [292:0] vB;
   int lat, bc, rise1, rise2;

   initial begin
      rst = 1'b1; start = 1'b0; stateIn = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstBusy",  293'(busy),   293'(0));
      checkOutput("rstDone",  293'(done),   293'(0));
      checkOutput("rstTag",   293'(tagOut), 293'(0));
      checkOutput("rstState", stateOut,     293'(0));
      checkEn = 1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      pinS = modelStep('0, pinKs);
      checkOutput("pinZeroStep", pinS, {1'b1, 292'b0});
      checkOutput("pinZeroKs", 293'(pinKs), 293'(0));
      pinS = modelStep(293'(1) << 12, pinKs);
      checkOutput("pinBit12Ks", 293'(pinKs), 293'(1));

      $display("[TB] zero state run");
      applyStimulus('0);
      runAndMeasure(0, '0, lat, bc, rise1);
      checkOutput("zeroLatency", 293'(lat), 293'(768));
      checkOutput("zeroBusyCycles", 293'(bc), 293'(768));
      repeat (3) @(posedge clk);
      #1;

      $display("[TB] all-ones state run");
      applyStimulus('1);
      runAndMeasure(0, '0, lat, bc, rise1);
      checkOutput("onesLatency", 293'(lat), 293'(768));
      checkOutput("onesTag", 293'(tagOut), 293'(0));
      checkOutput("onesState", stateOut, '1);

      $display("[TB] tag bit order");
      vA = randState();
      computeFinal(vA, eTag, eFin, eKs);
      applyStimulus(vA);
      runAndMeasure(0, '0, lat, bc, rise1);
      checkOutput("orderTagBit0",   293'(tagOut[0]),   293'(eKs[640]));
      checkOutput("orderTagBit127", 293'(tagOut[127]), 293'(eKs[767]));
      checkOutput("orderTag", 293'(tagOut), 293'(eTag));

      $display("[TB] ignored start mid-run");
      vA = randState();
      vB = randState();
      computeFinal(vA, eTag, eFin, eKs);
      applyStimulus(vA);
      runAndMeasure(100, vB, lat, bc, rise1);
      checkOutput("ignLatency", 293'(lat), 293'(768));
      checkOutput("ignBusyCycles", 293'(bc), 293'(768));
      checkOutput("ignTag", 293'(tagOut), 293'(eTag));
      checkOutput("ignState", stateOut, eFin);

      $display("[TB] reset mid-run");
      applyStimulus(randState());
      repeat (299) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midRstBusy",  293'(busy),   293'(0));
      checkOutput("midRstDone",  293'(done),   293'(0));
      checkOutput("midRstTag",   293'(tagOut), 293'(0));
      checkOutput("midRstState", stateOut,     293'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("postRstBusy", 293'(busy), 293'(0));
      checkOutput("postRstDone", 293'(done), 293'(0));

      $display("[TB] back-to-back with start held");
      vA = randState();
      vB = randState();
      start = 1'b1;
      stateIn = vA;
      @(posedge clk);
      #1;
      stateIn = vB;
      runAndMeasure(0, '0, lat, bc, rise1);
      checkOutput("b2bLatency1", 293'(lat), 293'(768));
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2bRestartDone", 293'(done), 293'(0));
      checkOutput("b2bRestartBusy", 293'(busy), 293'(1));
      computeFinal(vB, eTag, eFin, eKs);
      runAndMeasure(0, '0, lat, bc, rise2);
      checkOutput("b2bLatency2", 293'(lat), 293'(768));
      checkOutput("b2bGap", 293'(rise2 - rise1), 293'(769));
      checkOutput("b2bTag2", 293'(tagOut), 293'(eTag));

      $display("[TB] randomized runs");
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         applyStimulus(randState());
         runAndMeasure(int'($urandom_range(1, 700)), randState(), lat, bc, rise1);
         checkOutput("rndLatency", 293'(lat), 293'(768));
         checkOutput("rndBusyCycles", 293'(bc), 293'(768));
      end
      repeat (3) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
